// File: rtl/avalon_debug_poller.sv
// Avalon-MM master that polls a debug status word, turns new sequence numbers into
// {seq, code, gap} records and streams them out through a first-word fall-through FIFO.
module avalon_debug_poller #(
  parameter int ADDR_WIDTH    = 1,
  parameter int POLL_ADDR     = 0,
  parameter int POLL_INTERVAL = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter int TIMEOUT       = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_enable,
  output logic [ADDR_WIDTH-1:0] io_Avalon_address,
  output logic                  io_Avalon_read,
  input  logic [63:0]           io_Avalon_readdata,
  output logic                  io_Avalon_write,
  output logic [63:0]           io_Avalon_writedata,
  input  logic                  io_Avalon_waitrequest,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [7:0]            io_out_seq,
  output logic [4:0]            io_out_code,
  output logic [7:0]            io_out_gap,
  output logic [15:0]           io_dropped,
  output logic                  io_timeout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_EVAL = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int INT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [INT_W-1:0] INT_LAST = INT_W'(POLL_INTERVAL - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [1:0]       state_r;
  logic             read_r;
  logic [7:0]       smp_seq_r;
  logic [4:0]       smp_code_r;
  logic [7:0]       last_seq_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic [INT_W-1:0] int_cnt_r;
  logic             timeout_r;

  logic [20:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [15:0]      dropped_r;

  logic             push_req_s;
  logic             push_s;
  logic             pop_s;
  logic             drop_s;
  logic             full_s;
  logic [7:0]       gap_s;
  logic [20:0]      head_s;
  logic             unused_bits_s;

  assign unused_bits_s = ^io_Avalon_readdata[55:5];

  // Push/pop/drop decisions for the record FIFO; a full FIFO still takes a push on a pop cycle.
  always_comb begin
    full_s     = (count_r == CNT_FULL);
    pop_s      = (count_r != {CNT_W{1'b0}}) && io_out_ready;
    push_req_s = (state_r == ST_EVAL) && (smp_seq_r != last_seq_r);
    push_s     = push_req_s && (!full_s || pop_s);
    drop_s     = push_req_s && full_s && !pop_s;
    gap_s      = smp_seq_r - last_seq_r - 8'd1;
    head_s     = mem_r[rd_ptr_r];
  end

  // Poll sequencer: issues the read, handles stall timeout and the inter-poll wait.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      read_r     <= 1'b0;
      smp_seq_r  <= 8'd0;
      smp_code_r <= 5'd0;
      last_seq_r <= 8'd0;
      tmo_cnt_r  <= {TMO_W{1'b0}};
      int_cnt_r  <= {INT_W{1'b0}};
      timeout_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (io_enable) begin
            state_r   <= ST_READ;
            read_r    <= 1'b1;
            tmo_cnt_r <= {TMO_W{1'b0}};
          end
        end
        ST_READ: begin
          if (!io_Avalon_waitrequest) begin
            smp_seq_r  <= io_Avalon_readdata[63:56];
            smp_code_r <= io_Avalon_readdata[4:0];
            read_r     <= 1'b0;
            state_r    <= ST_EVAL;
          end else if (tmo_cnt_r == TMO_LAST) begin
            read_r    <= 1'b0;
            timeout_r <= 1'b1;
            int_cnt_r <= {INT_W{1'b0}};
            state_r   <= ST_WAIT;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
          end
        end
        ST_EVAL: begin
          // last_seq advances even when the record is dropped for lack of space
          last_seq_r <= smp_seq_r;
          int_cnt_r  <= {INT_W{1'b0}};
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (int_cnt_r == INT_LAST) begin
            if (io_enable) begin
              state_r   <= ST_READ;
              read_r    <= 1'b1;
              tmo_cnt_r <= {TMO_W{1'b0}};
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            int_cnt_r <= int_cnt_r + {{(INT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          read_r  <= 1'b0;
        end
      endcase
    end
  end

  // Record FIFO storage, pointers, occupancy and the saturating drop counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 21'd0;
      end
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      dropped_r <= 16'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {smp_seq_r, smp_code_r, gap_s};
        wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
      if (drop_s && (dropped_r != 16'hFFFF)) begin
        dropped_r <= dropped_r + 16'd1;
      end
    end
  end

  assign io_Avalon_address   = ADDR_WIDTH'(POLL_ADDR);
  assign io_Avalon_read      = read_r;
  assign io_Avalon_write     = 1'b0;
  assign io_Avalon_writedata = 64'd0;
  assign io_out_valid        = (count_r != {CNT_W{1'b0}});
  assign io_out_seq          = head_s[20:13];
  assign io_out_code         = head_s[12:8];
  assign io_out_gap          = head_s[7:0];
  assign io_dropped          = dropped_r;
  assign io_timeout          = timeout_r;

endmodule
